// File: rtl/alu_result_display_pkg.sv
// Shared types, codes and helpers for the ALU result display stage.
// Optional build macro ALU_DISP_BLANK_EN selects leading-zero blanking (see blank_lead).
package alu_result_display_pkg;

  localparam int unsigned AluWidth = 6;
  localparam int unsigned OutW     = 2 * AluWidth;
  localparam int unsigned MagBits  = 11;

  localparam logic [3:0] GlyphErr   = 4'hE;
  localparam logic [3:0] GlyphBlank = 4'hF;

  typedef enum logic [1:0] {
    FuncAdd = 2'b00,
    FuncSub = 2'b01,
    FuncMul = 2'b10,
    FuncDiv = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StStore,
    StErr
  } state_e;

  // Div is shown as two unsigned fields: quotient first, remainder on the second pass.
  function automatic logic [OutW-1:0] sel_value(func_e f, logic [OutW-1:0] v, logic rem);
    logic [OutW-1:0] r;
    unique case (f)
      FuncMul: r = v;
      FuncDiv: r = rem ? {{AluWidth{1'b0}}, v[AluWidth-1:0]}
                       : {{AluWidth{1'b0}}, v[OutW-1:AluWidth]};
      default: r = {{AluWidth{v[AluWidth-1]}}, v[AluWidth-1:0]};
    endcase
    return r;
  endfunction

  function automatic logic value_neg(func_e f, logic [OutW-1:0] v);
    logic n;
    unique case (f)
      FuncMul: n = v[OutW-1];
      FuncDiv: n = 1'b0;
      default: n = v[AluWidth-1];
    endcase
    return n;
  endfunction

  function automatic logic [MagBits-1:0] abs_mag(logic [OutW-1:0] v);
    logic [OutW-1:0] a;
    a = v[OutW-1] ? -v : v;
    return a[MagBits-1:0];
  endfunction

  function automatic logic [15:0] blank_lead(logic [15:0] d, logic is_div);
    logic [15:0] r;
    r = d;
    if (is_div) begin
      if (d[15:12] == 4'h0) r[15:12] = GlyphBlank;
      if (d[7:4] == 4'h0) r[7:4] = GlyphBlank;
    end else if (d[15:12] == 4'h0) begin
      r[15:12] = GlyphBlank;
      if (d[11:8] == 4'h0) begin
        r[11:8] = GlyphBlank;
        if (d[7:4] == 4'h0) r[7:4] = GlyphBlank;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Capture request / display result bundle between alu_top and the display stage.
interface alu_result_display_if;
  logic                                                start;
  alu_result_display_pkg::func_e                       func;
  logic [alu_result_display_pkg::OutW-1:0]             out;
  logic                                                overflow;
  logic                                                busy;
  logic                                                done;
  logic                                                neg;
  logic [15:0]                                         digits;

  modport master (output start, func, out, overflow, input busy, done, neg, digits);
  modport slave  (input start, func, out, overflow, output busy, done, neg, digits);
endinterface

// File: rtl/alu_result_display_bcd_double_dabble.sv
// Sequential binary-to-BCD converter: one add-3-then-shift step per clock after load.
module alu_result_display_bcd_double_dabble #(
  parameter int unsigned MagBits = 11
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [MagBits-1:0] mag,
  output logic [15:0]        bcd,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(MagBits + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(MagBits);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [MagBits-1:0] bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [15:0]        adj;

  always_comb begin
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    adj   = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (load) begin
      cnt_d = CntInit;
      bin_d = mag;
      bcd_d = '0;
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result and converts it to sign + 4 BCD digits for the 7-segment driver.
// Build macro ALU_DISP_BLANK_EN replaces leading-zero digits with the blank glyph.
module alu_result_display
  import alu_result_display_pkg::*;
(
  input logic                 clock,
  input logic                 reset_n,
  alu_result_display_if.slave disp_if
);

  state_e              state_q, state_d;
  func_e               func_q, func_d;
  logic [OutW-1:0]     out_q, out_d;
  logic                pass_q, pass_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         digits_q, digits_d;
  logic                neg_q, neg_d;
  logic [15:0]         conv_digits;
  logic                dd_load, dd_busy;
  logic [MagBits-1:0]  dd_mag;
  logic [15:0]         dd_bcd;

  alu_result_display_bcd_double_dabble #(
    .MagBits (MagBits)
  ) u_bcd_double_dabble (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (dd_load),
    .mag     (dd_mag),
    .bcd     (dd_bcd),
    .busy    (dd_busy)
  );

  always_comb begin
    conv_digits = (func_q == FuncDiv) ? {hi_q, dd_bcd[7:0]} : dd_bcd;
`ifdef ALU_DISP_BLANK_EN
    conv_digits = blank_lead(conv_digits, func_q == FuncDiv);
`endif
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    out_d    = out_q;
    pass_d   = pass_q;
    hi_d     = hi_q;
    digits_d = digits_q;
    neg_d    = neg_q;
    dd_load  = 1'b0;
    dd_mag   = abs_mag(sel_value(disp_if.func, disp_if.out, 1'b0));
    unique case (state_q)
      // The done cycle (StStore) also accepts a new start so runs can go back to back.
      StIdle, StStore: begin
        state_d = StIdle;
        if (disp_if.start) begin
          func_d = disp_if.func;
          out_d  = disp_if.out;
          pass_d = 1'b0;
          if (disp_if.overflow && (disp_if.func == FuncAdd || disp_if.func == FuncSub)) begin
            state_d = StErr;
          end else begin
            dd_load = 1'b1;
            state_d = StShift;
          end
        end
      end
      StErr: begin
        digits_d = {4{GlyphErr}};
        neg_d    = 1'b0;
        state_d  = StStore;
      end
      StShift: begin
        if (!dd_busy) begin
          if (func_q == FuncDiv && !pass_q) begin
            hi_d    = dd_bcd[7:0];
            pass_d  = 1'b1;
            dd_load = 1'b1;
            dd_mag  = abs_mag(sel_value(func_q, out_q, 1'b1));
          end else begin
            digits_d = conv_digits;
            neg_d    = value_neg(func_q, out_q);
            state_d  = StStore;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      func_q   <= FuncAdd;
      out_q    <= '0;
      pass_q   <= 1'b0;
      hi_q     <= '0;
      digits_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      out_q    <= out_d;
      pass_q   <= pass_d;
      hi_q     <= hi_d;
      digits_q <= digits_d;
      neg_q    <= neg_d;
    end
  end

  assign disp_if.busy   = (state_q == StShift) || (state_q == StErr);
  assign disp_if.done   = (state_q == StStore);
  assign disp_if.neg    = neg_q;
  assign disp_if.digits = digits_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed self-checking bench for alu_result_display (honours ALU_DISP_BLANK_EN if defined).
module tb_alu_result_display;
  import alu_result_display_pkg::*;

  logic clock;
  logic reset_n;
  int   n_pass;
  int   n_total;

`ifdef ALU_DISP_BLANK_EN
  localparam logic [15:0] X0017 = 16'hFF17, X0032 = 16'hFF32, X1024 = 16'h1024;
  localparam logic [15:0] X0992 = 16'hF992, X0703 = 16'hF7F3, X6363 = 16'h6363;
  localparam logic [15:0] X0005D = 16'hF0F5, X0005 = 16'hFFF5, X0012 = 16'hFF12;
  localparam logic [15:0] X0099 = 16'hFF99, X0001 = 16'hFFF1;
`else
  localparam logic [15:0] X0017 = 16'h0017, X0032 = 16'h0032, X1024 = 16'h1024;
  localparam logic [15:0] X0992 = 16'h0992, X0703 = 16'h0703, X6363 = 16'h6363;
  localparam logic [15:0] X0005D = 16'h0005, X0005 = 16'h0005, X0012 = 16'h0012;
  localparam logic [15:0] X0099 = 16'h0099, X0001 = 16'h0001;
`endif

  alu_result_display_if bus ();

  alu_result_display dut (
    .clock   (clock),
    .reset_n (reset_n),
    .disp_if (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimal reference for a non-div magnitude, including optional leading blanking.
  function automatic logic [15:0] exp_dec(int mag);
    logic [15:0] r;
    r[15:12] = 4'(mag / 1000);
    r[11:8]  = 4'((mag / 100) % 10);
    r[7:4]   = 4'((mag / 10) % 10);
    r[3:0]   = 4'(mag % 10);
`ifdef ALU_DISP_BLANK_EN
    if (mag < 1000) r[15:12] = 4'hF;
    if (mag < 100) r[11:8] = 4'hF;
    if (mag < 10) r[7:4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic do_op(input func_e f, input logic [11:0] o, input logic ovf,
                       output int lat, output logic busy_e0);
    @(negedge clock);
    bus.start    = 1'b1;
    bus.func     = f;
    bus.out      = o;
    bus.overflow = ovf;
    @(posedge clock);
    #1;
    busy_e0   = bus.busy;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_total += 4;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    if (bus.neg !== 1'b0) $display("FAIL reset_neg got %b want 0", bus.neg); else n_pass++;
    if (bus.digits !== 16'h0000) $display("FAIL reset_digits got %h want 0000", bus.digits);
    else n_pass++;
  endtask

  task automatic test_add();
    int lat;
    logic b;
    do_op(FuncAdd, 12'h011, 1'b0, lat, b);
    n_total += 4;
    if (b !== 1'b1) $display("FAIL add_busy_e0 got %b want 1", b); else n_pass++;
    if (lat != 12) $display("FAIL add_latency got %0d want 12", lat); else n_pass++;
    if (bus.digits !== X0017) $display("FAIL add_digits got %h want %h", bus.digits, X0017);
    else n_pass++;
    if (bus.neg !== 1'b0) $display("FAIL add_neg got %b want 0", bus.neg); else n_pass++;
    @(posedge clock);
    #1;
    n_total += 2;
    if (bus.done !== 1'b0) $display("FAIL add_done_width got %b want 0", bus.done); else n_pass++;
    if (bus.digits !== X0017) $display("FAIL add_hold got %h want %h", bus.digits, X0017);
    else n_pass++;
  endtask

  task automatic test_sub();
    int lat;
    logic b;
    do_op(FuncSub, 12'h020, 1'b0, lat, b);
    n_total += 3;
    if (lat != 12) $display("FAIL sub_latency got %0d want 12", lat); else n_pass++;
    if (bus.neg !== 1'b1) $display("FAIL sub_m32_neg got %b want 1", bus.neg); else n_pass++;
    if (bus.digits !== X0032) $display("FAIL sub_m32_digits got %h want %h", bus.digits, X0032);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int lat;
    logic b;
    do_op(FuncAdd, 12'h011, 1'b1, lat, b);
    n_total += 4;
    if (b !== 1'b1) $display("FAIL ovf_busy_e0 got %b want 1", b); else n_pass++;
    if (lat != 1) $display("FAIL ovf_latency got %0d want 1", lat); else n_pass++;
    if (bus.digits !== 16'hEEEE) $display("FAIL ovf_digits got %h want eeee", bus.digits);
    else n_pass++;
    if (bus.neg !== 1'b0) $display("FAIL ovf_neg got %b want 0", bus.neg); else n_pass++;
    do_op(FuncMul, 12'h005, 1'b1, lat, b);
    n_total += 2;
    if (lat != 12) $display("FAIL ovf_mul_latency got %0d want 12", lat); else n_pass++;
    if (bus.digits !== X0005) $display("FAIL ovf_mul_digits got %h want %h", bus.digits, X0005);
    else n_pass++;
  endtask

  task automatic test_mul();
    int lat;
    logic b;
    do_op(FuncMul, 12'h400, 1'b0, lat, b);
    n_total += 3;
    if (lat != 12) $display("FAIL mul_latency got %0d want 12", lat); else n_pass++;
    if (bus.digits !== X1024) $display("FAIL mul_1024 got %h want %h", bus.digits, X1024);
    else n_pass++;
    if (bus.neg !== 1'b0) $display("FAIL mul_1024_neg got %b want 0", bus.neg); else n_pass++;
    do_op(FuncMul, 12'hC20, 1'b0, lat, b);
    n_total += 2;
    if (bus.digits !== X0992) $display("FAIL mul_m992 got %h want %h", bus.digits, X0992);
    else n_pass++;
    if (bus.neg !== 1'b1) $display("FAIL mul_m992_neg got %b want 1", bus.neg); else n_pass++;
  endtask

  task automatic test_div();
    int lat;
    logic b;
    do_op(FuncDiv, {6'd7, 6'd3}, 1'b0, lat, b);
    n_total += 3;
    if (lat != 24) $display("FAIL div_latency got %0d want 24", lat); else n_pass++;
    if (bus.digits !== X0703) $display("FAIL div_7r3 got %h want %h", bus.digits, X0703);
    else n_pass++;
    if (bus.neg !== 1'b0) $display("FAIL div_neg got %b want 0", bus.neg); else n_pass++;
    do_op(FuncDiv, 12'hFFF, 1'b0, lat, b);
    n_total += 2;
    if (bus.digits !== X6363) $display("FAIL div_63r63 got %h want %h", bus.digits, X6363);
    else n_pass++;
    if (bus.neg !== 1'b0) $display("FAIL div_63r63_neg got %b want 0", bus.neg); else n_pass++;
    do_op(FuncDiv, {6'd0, 6'd5}, 1'b0, lat, b);
    n_total += 1;
    if (bus.digits !== X0005D) $display("FAIL div_0r5 got %h want %h", bus.digits, X0005D);
    else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int lat;
    int extra;
    @(negedge clock);
    bus.start = 1'b1;
    bus.func  = FuncMul;
    bus.out   = 12'h00C;
    bus.overflow = 1'b0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bus.start = 1'b1;
        bus.func  = FuncAdd;
        bus.out   = 12'h001;
      end
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) extra++;
    end
    n_total += 3;
    if (lat != 12) $display("FAIL ign_latency got %0d want 12", lat); else n_pass++;
    if (bus.digits !== X0012) $display("FAIL ign_digits got %h want %h", bus.digits, X0012);
    else n_pass++;
    if (extra != 0) $display("FAIL ign_extra_done got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic b;
    do_op(FuncAdd, 12'h005, 1'b0, lat1, b);
    do_op(FuncSub, 12'h03F, 1'b0, lat2, b);
    n_total += 5;
    if (lat1 != 12) $display("FAIL b2b_lat1 got %0d want 12", lat1); else n_pass++;
    if (b !== 1'b1) $display("FAIL b2b_busy_e0 got %b want 1", b); else n_pass++;
    if (lat2 != 12) $display("FAIL b2b_lat2 got %0d want 12", lat2); else n_pass++;
    if (bus.digits !== X0001) $display("FAIL b2b_digits got %h want %h", bus.digits, X0001);
    else n_pass++;
    if (bus.neg !== 1'b1) $display("FAIL b2b_neg got %b want 1", bus.neg); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic b;
    @(negedge clock);
    bus.start = 1'b1;
    bus.func  = FuncMul;
    bus.out   = 12'h063;
    bus.overflow = 1'b0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_total += 3;
    if (bus.busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", bus.busy); else n_pass++;
    if (bus.done !== 1'b0) $display("FAIL rmid_done got %b want 0", bus.done); else n_pass++;
    if (bus.digits !== 16'h0000) $display("FAIL rmid_digits got %h want 0000", bus.digits);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    do_op(FuncMul, 12'h063, 1'b0, lat, b);
    n_total += 2;
    if (lat != 12) $display("FAIL rmid_after_lat got %0d want 12", lat); else n_pass++;
    if (bus.digits !== X0099) $display("FAIL rmid_after_digits got %h want %h", bus.digits, X0099);
    else n_pass++;
  endtask

  task automatic test_sweep_add();
    int lat;
    logic b;
    int sv;
    int mag;
    logic [15:0] exp_d;
    for (int v = 0; v < 64; v++) begin
      sv  = (v >= 32) ? v - 64 : v;
      mag = (sv < 0) ? -sv : sv;
      exp_d = exp_dec(mag);
      do_op(FuncAdd, 12'(v), 1'b0, lat, b);
      n_total += 2;
      if (bus.digits !== exp_d)
        $display("FAIL sweep_digits v=%0d got %h want %h", sv, bus.digits, exp_d);
      else n_pass++;
      if (bus.neg !== (sv < 0))
        $display("FAIL sweep_neg v=%0d got %b want %b", sv, bus.neg, (sv < 0));
      else n_pass++;
    end
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.func     = FuncAdd;
    bus.out      = '0;
    bus.overflow = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset_n = 1'b1;
    test_add();
    test_sub();
    test_overflow();
    test_mul();
    test_div();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_sweep_add();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
